alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, handshaked ALU: successor to the fixed 8-bit combinational ALU. Registered result + flags,
//  valid/ready on input and output, iterative shift-add multiply (multi-cycle FSM), illegal-opcode flag.
//  Sits between the decode stage (producer) and writeback (consumer) of the datapath.
// PARAMETERS
//  WIDTH   8  operand/result width (>=4); shift amount = b_i[$clog2(WIDTH)-1:0]
//  MUL_EN  1  1 = MUL implemented; 0 = MUL opcode treated as illegal
// PORTS
//  clk          in   1      sole clock, rising edge
//  rst_n        in   1      synchronous, active-low reset
//  in_valid_i   in   1      operands/opcode valid
//  in_ready_o   out  1      block accepts this cycle
//  opcode_i     in   4      operation (alu_pkg encoding)
//  a_i          in   WIDTH  operand A
//  b_i          in   WIDTH  operand B
//  out_valid_o  out  1      z_o/flags valid
//  out_ready_i  in   1      consumer accepts this cycle
//  z_o          out  WIDTH  result
//  zero_o       out  1      z_o == 0
//  neg_o        out  1      z_o[WIDTH-1]
//  carry_o      out  1      ADD carry-out / SUB borrow; 0 otherwise
//  ovrflw_o     out  1      ADD/SUB signed overflow; MUL product exceeds WIDTH bits; 0 otherwise
//  err_o        out  1      illegal opcode
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, out_valid_o=0, z_o=0, all flags 0; in_ready_o=1 after reset.
//    Reset mid-MUL aborts it; no result for the aborted op ever appears.
//  - Accept = in_valid_i & in_ready_o. in_ready_o = (state==IDLE) & (!out_valid_o | out_ready_i).
//  - Output register holds z_o/flags stable while out_valid_o & !out_ready_i. out_valid_o clears on
//    out_ready_i unless a new result loads the same cycle (load wins).
//  - Single-cycle ops: result on out_valid_o 1 cycle after accept; full throughput 1 op/cycle.
//  - Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed,
//    z=1/0), 10 SLTU, 11 PASS b, 12 MUL (low WIDTH bits, unsigned), 13-15 illegal.
//  - Illegal (incl. MUL when MUL_EN=0): z_o=0, err_o=1, zero_o=1, latency 1.
//  - Arithmetic on WIDTH+1 bits; carry_o = bit WIDTH for ADD, borrow (a<b unsigned) for SUB.
//    ovrflw_o(ADD) = a,b same sign & z sign differs; (SUB) = a,b differ in sign & z sign != a sign.
//  - Shift amount modulo WIDTH (low $clog2(WIDTH) bits of b_i); upper b_i bits ignored.
//  - MUL FSM: IDLE -accept MUL-> MUL (WIDTH cycles, one multiplier bit/cycle, 2*WIDTH accumulator)
//    -> DONE (load output reg when !out_valid_o | out_ready_i, else wait) -> IDLE.
//    Latency accept->out_valid_o = WIDTH+1 with no backpressure. in_ready_o=0 in MUL and DONE.
//    ovrflw_o = |product[2W-1:W]; carry_o=0.
//  - zero_o/neg_o always derived from the registered z_o value.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding (ST_IDLE, ST_MUL, ST_DONE).
//  - Sub-module alu_mul_seq: start/done shift-add multiplier, WIDTH param, 2*WIDTH product, sync reset.
//  - Top: combinational single-cycle unit, FSM, output register + handshake.
// TESTING (WIDTH=8 unless noted)
//  - ADD 0x7F+0x01 -> z=0x80 ovrflw=1 neg=1 carry=0, out_valid 1 cycle after accept;
//    ADD 0xFF+0x01 -> z=0x00 zero=1 carry=1 ovrflw=0.
//  - SUB 0x00-0x01 -> z=0xFF carry=1 neg=1; SUB 0x80-0x01 -> z=0x7F ovrflw=1; SLL 0x01 by b=0x09 -> 0x02.
//  - MUL 0x0F*0x11 -> z=0xFF ovrflw=0, out_valid exactly 9 cycles after accept, in_ready=0 throughout;
//    MUL 0x10*0x10 -> z=0x00 zero=1 ovrflw=1.
//  - Backpressure: 4 back-to-back ADDs, out_ready=0 for 5 cycles -> z_o stable, in_ready=0, then all 4
//    results delivered in order at 1/cycle after out_ready=1, none lost or duplicated.
//  - Reset mid-MUL: rst_n=0 on cycle 4 of MUL -> next edge out_valid=0, z=0, in_ready=1; no MUL result.
//  - Illegal opcode 0xF -> z=0 err=1 zero=1; with MUL_EN=0, opcode 12 -> err=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the handshaked ALU: opcode values and control FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_PASS = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, full 2*WIDTH product.
// Bit 0 is folded in on the start edge so the last bit is consumed WIDTH-1 cycles later.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,   // synchronous, active-low
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,   // high during the cycle the final bit is consumed
    output logic [2*WIDTH-1:0] product_o
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Load operands on start, then accumulate one shifted partial product per cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{(WIDTH - 1){1'b0}}, a_i, 1'b0};
            acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
            mplier_q <= b_i >> 1;
            cnt_q    <= CW'(1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o    = busy_q && (cnt_q == LastCnt);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops load the output register on accept; MUL runs through
// a sequential multiplier under a small FSM. Output register stalls under backpressure.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] z_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovrflw_o,
    output logic             err_o
);
    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e state_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] z_q;
    logic             zero_q, neg_q, carry_q, ovrflw_q, err_q;

    logic             accept, is_mul, out_free, load_single, load_mul, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_z, ld_z;
    logic             res_c, res_v, res_e;
    logic             ld_c, ld_v, ld_e;

    assign is_mul      = MUL_EN && (opcode_i == OP_MUL);
    assign out_free    = !out_valid_q || out_ready_i;
    assign in_ready_o  = (state_q == ST_IDLE) && out_free;
    assign accept      = in_valid_i && in_ready_o;
    assign load_single = accept && !is_mul;
    assign load_mul    = (state_q == ST_DONE) && out_free;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (accept && is_mul),
        .a_i       (a_i),
        .b_i       (b_i),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Single-cycle datapath; arithmetic carried on WIDTH+1 bits for carry/borrow
    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = {1'b0, a_i} - {1'b0, b_i};
        shamt = b_i[SHW-1:0];
        res_z = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_e = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                res_z = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_z = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  res_z = a_i & b_i;
            OP_OR:   res_z = a_i | b_i;
            OP_XOR:  res_z = a_i ^ b_i;
            OP_NOT:  res_z = ~a_i;
            OP_SLL:  res_z = a_i << shamt;
            OP_SRL:  res_z = a_i >> shamt;
            OP_SRA:  res_z = $signed(a_i) >>> shamt;
            OP_SLT:  res_z = {{(WIDTH - 1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: res_z = {{(WIDTH - 1){1'b0}}, (a_i < b_i)};
            OP_PASS: res_z = b_i;
            // MUL only reaches here when disabled; it is then illegal like 13-15
            default: res_e = 1'b1;
        endcase
    end

    // Select what the output register captures: finished product or single-cycle result
    always_comb begin
        ld_z = res_z;
        ld_c = res_c;
        ld_v = res_v;
        ld_e = res_e;
        if (load_mul) begin
            ld_z = mul_prod[WIDTH-1:0];
            ld_c = 1'b0;
            ld_v = |mul_prod[2*WIDTH-1:WIDTH];
            ld_e = 1'b0;
        end
    end

    // Control FSM and output register; a new load wins over a consumer pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovrflw_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept && is_mul) state_q <= ST_MUL;
                ST_MUL:  if (mul_done) state_q <= ST_DONE;
                ST_DONE: if (out_free) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            if (load_single || load_mul) begin
                out_valid_q <= 1'b1;
                z_q         <= ld_z;
                zero_q      <= (ld_z == '0);
                neg_q       <= ld_z[WIDTH-1];
                carry_q     <= ld_c;
                ovrflw_q    <= ld_v;
                err_q       <= ld_e;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign z_o         = z_q;
    assign zero_o      = zero_q;
    assign neg_o       = neg_q;
    assign carry_o     = carry_q;
    assign ovrflw_o    = ovrflw_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed, random, streaming, reset and MUL_EN=0.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] opcode;
    logic [7:0] a, b, z;
    logic       zero, neg, carry, ovrflw, err;

    logic       m0_in_valid, m0_in_ready, m0_out_valid;
    logic [3:0] m0_opcode;
    logic [7:0] m0_a, m0_b, m0_z;
    logic       m0_zero, m0_neg, m0_carry, m0_ovrflw, m0_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .opcode_i(opcode), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .z_o(z), .zero_o(zero), .neg_o(neg), .carry_o(carry), .ovrflw_o(ovrflw), .err_o(err)
    );

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid_i(m0_in_valid), .in_ready_o(m0_in_ready),
        .opcode_i(m0_opcode), .a_i(m0_a), .b_i(m0_b), .out_valid_o(m0_out_valid),
        .out_ready_i(1'b1), .z_o(m0_z), .zero_o(m0_zero), .neg_o(m0_neg),
        .carry_o(m0_carry), .ovrflw_o(m0_ovrflw), .err_o(m0_err)
    );

    // Reference: result and flags from plain integer arithmetic, packed {z,c,v,n,zr,e}
    function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] ai, bi);
        int ua = ai;
        int ub = bi;
        int sa = $signed(ai);
        int sb = $signed(bi);
        int sh = ub % 8;
        int r  = 0;
        logic [7:0] zz = 8'h00;
        logic c = 1'b0, v = 1'b0, e = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; zz = r[7:0]; c = (r > 255);
                        v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ua - ub; zz = r[7:0]; c = (ua < ub);
                        v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: zz = ai & bi;
            4'd3: zz = ai | bi;
            4'd4: zz = ai ^ bi;
            4'd5: zz = ~ai;
            4'd6: begin r = ua * (1 << sh); zz = r[7:0]; end
            4'd7: begin r = ua / (1 << sh); zz = r[7:0]; end
            4'd8: begin r = sa >>> sh; zz = r[7:0]; end
            4'd9: zz = (sa < sb) ? 8'd1 : 8'd0;
            4'd10: zz = (ua < ub) ? 8'd1 : 8'd0;
            4'd11: zz = bi;
            4'd12: begin r = ua * ub; zz = r[7:0]; v = (r > 255); end
            default: e = 1'b1;
        endcase
        return {zz, c, v, zz[7], (zz == 8'h00), e};
    endfunction

    // Issue one op with out_ready=1; report observed outputs, latency, and in_ready leaks
    task automatic do_op(input logic [3:0] op, input logic [7:0] ai, bi,
                         output logic [12:0] obs, output int lat, output int rdy_bad);
        int w = 0;
        rdy_bad = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            total++; bad++;
            $display("FAIL issue_wait in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1; opcode = op; a = ai; b = bi;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) rdy_bad++;
            @(negedge clk);
            lat++;
        end
        obs = {z, carry, ovrflw, neg, zero, err};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; m0_in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, z, zero, neg, carry, ovrflw, err} !== 14'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {out_valid, z, zero, neg, carry, ovrflw, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || m0_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b%b required=11", in_ready, m0_in_ready);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [12:0] exp;
        logic [4:0]  lat;
    } vec_t;

    task automatic test_directed();
        vec_t v [12];
        logic [12:0] obs;
        int lat, rb;
        // exp = {z, carry, ovrflw, neg, zero, err}
        v[0]  = '{4'd0,  8'h7F, 8'h01, {8'h80, 5'b01100}, 5'd1};
        v[1]  = '{4'd0,  8'hFF, 8'h01, {8'h00, 5'b10010}, 5'd1};
        v[2]  = '{4'd1,  8'h00, 8'h01, {8'hFF, 5'b10100}, 5'd1};
        v[3]  = '{4'd1,  8'h80, 8'h01, {8'h7F, 5'b01000}, 5'd1};
        v[4]  = '{4'd6,  8'h01, 8'h09, {8'h02, 5'b00000}, 5'd1};
        v[5]  = '{4'd12, 8'h0F, 8'h11, {8'hFF, 5'b00100}, 5'd9};
        v[6]  = '{4'd12, 8'h10, 8'h10, {8'h00, 5'b01010}, 5'd9};
        v[7]  = '{4'd15, 8'h12, 8'h34, {8'h00, 5'b00011}, 5'd1};
        v[8]  = '{4'd8,  8'h80, 8'h03, {8'hF0, 5'b00100}, 5'd1};
        v[9]  = '{4'd9,  8'hFF, 8'h01, {8'h01, 5'b00000}, 5'd1};
        v[10] = '{4'd10, 8'hFF, 8'h01, {8'h00, 5'b00010}, 5'd1};
        v[11] = '{4'd5,  8'h0F, 8'h00, {8'hF0, 5'b00100}, 5'd1};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, obs, lat, rb);
            total++;
            if (obs !== v[i].exp) begin
                bad++;
                $display("FAIL directed_%0d result got=%h required=%h", i, obs, v[i].exp);
            end
            total++;
            if (lat != int'(v[i].lat)) begin
                bad++;
                $display("FAIL directed_%0d latency got=%0d required=%0d", i, lat, v[i].lat);
            end
            if (v[i].op == 4'd12) begin
                total++;
                if (rb != 0) begin
                    bad++;
                    $display("FAIL directed_%0d mul_in_ready high_cycles=%0d required=0", i, rb);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] obs, exp;
        logic [3:0] op;
        logic [7:0] ai, bi;
        int lat, rb;
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            ai = 8'($urandom);
            bi = 8'($urandom);
            exp = model(op, ai, bi);
            do_op(op, ai, bi, obs, lat, rb);
            total++;
            if (obs !== exp || lat != ((op == 4'd12) ? 9 : 1)) begin
                bad++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h lat=%0d required=%h lat=%0d",
                         i, op, ai, bi, obs, lat, exp, (op == 4'd12) ? 9 : 1);
            end
        end
    endtask

    // Producer/consumer stream with an initial out_ready=0 window of 'stall' cycles
    task automatic test_stream(input string nm, input int n, input int stall, input bit add_only);
        logic [12:0] exp_q [$];
        logic [12:0] obs, exp;
        logic [3:0] cop;
        logic [7:0] ca, cb, held_z;
        int sent = 0, got = 0, first = -1, last = -1, r;
        bit prev_stall = 0;
        cop = add_only ? 4'd0 : 4'd2; ca = 8'($urandom); cb = 8'($urandom);
        for (int cyc = 0; cyc < n + stall + 10; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid = (sent < n);
            opcode = cop; a = ca; b = cb;
            #1;
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0 || (prev_stall && z !== held_z)) begin
                    bad++;
                    $display("FAIL %s stall_hold z=%h in_ready=%b required z=%h in_ready=0",
                             nm, z, in_ready, held_z);
                end
                held_z = z;
                prev_stall = 1;
            end else begin
                prev_stall = 0;
            end
            if (out_valid === 1'b1 && out_ready) begin
                obs = {z, carry, ovrflw, neg, zero, err};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_result got=%h required=none", nm, obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        bad++;
                        $display("FAIL %s result_%0d got=%h required=%h", nm, got, obs, exp);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (stall == 0 && in_valid) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s throughput in_ready=%b required=1", nm, in_ready);
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(cop, ca, cb));
                sent++;
                r = $urandom_range(0, 14);
                if (r >= 12) r++;
                cop = add_only ? 4'd0 : 4'(r);
                ca = 8'($urandom); cb = 8'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (got != n || last - first != n - 1) begin
            bad++;
            $display("FAIL %s delivery got=%0d span=%0d required=%0d span=%0d",
                     nm, got, last - first, n, n - 1);
        end
    endtask

    task automatic test_mul_reset();
        int seen = 0;
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd12; a = 8'h0F; b = 8'h11;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || z !== 8'h00 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mul_reset out_valid=%b z=%h in_ready=%b required 0 00 1",
                     out_valid, z, in_ready);
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mul_reset_ghost valid_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_mul_disabled();
        @(negedge clk);
        m0_in_valid = 1'b1; m0_opcode = 4'd12; m0_a = 8'h03; m0_b = 8'h05;
        @(posedge clk);
        #1 m0_in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({m0_out_valid, m0_z, m0_err, m0_zero, m0_carry, m0_ovrflw, m0_neg}
                !== {1'b1, 8'h00, 1'b1, 1'b1, 3'b000}) begin
            bad++;
            $display("FAIL mul_disabled valid=%b z=%h err=%b zero=%b required 1 00 1 1",
                     m0_out_valid, m0_z, m0_err, m0_zero);
        end
    endtask

    initial begin
        in_valid = 1'b0; opcode = 4'd0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
        m0_in_valid = 1'b0; m0_opcode = 4'd0; m0_a = 8'h00; m0_b = 8'h00;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stream("backpressure", 4, 5, 1'b1);
        test_stream("back_to_back", 24, 0, 1'b0);
        test_mul_reset();
        test_mul_disabled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
